// File: rtl/pmem_sched_pkg.sv
// rtl/pmem_sched_pkg.sv - shared types for the physical-memory port scheduler
package pmem_sched_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [255:0] lc3b_block;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L2   = 2'd1,
    PF   = 2'd2
  } pmem_sched_state_t;

endpackage

// File: rtl/pmem_sched.sv
// rtl/pmem_sched.sv - arbitrates the pmem port between L2 demand and next-line prefetch
module pmem_sched
  import pmem_sched_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int BLOCK_W      = 256,
  parameter int OFFSET_W     = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               l2_read,
  input  logic               l2_write,
  input  logic [ADDR_W-1:0]  l2_address,
  input  logic [BLOCK_W-1:0] l2_wdata,
  output logic               l2_resp,
  output logic [BLOCK_W-1:0] l2_rdata,
  input  logic               pf_read,
  input  logic [ADDR_W-1:0]  pf_address,
  output logic               pf_resp,
  output logic [BLOCK_W-1:0] pf_rdata,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [ADDR_W-1:0]  pmem_address,
  output logic [BLOCK_W-1:0] pmem_wdata,
  input  logic               pmem_resp,
  input  logic [BLOCK_W-1:0] pmem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  pmem_sched_state_t r_state;
  pmem_sched_state_t w_next;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              w_forced;
  logic              w_merge;

  assign w_forced = pf_read && (r_starve_cnt == CNT_MAX);
  // Only demand reads to the same block may ride on the prefetch transfer.
  assign w_merge  = l2_read && (l2_address[ADDR_W-1:OFFSET_W] == pf_address[ADDR_W-1:OFFSET_W]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == PF) begin
        r_starve_cnt <= '0;
      end else if (pf_read && r_state != PF && r_starve_cnt != CNT_MAX) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    l2_resp      = 1'b0;
    l2_rdata     = '0;
    pf_resp      = 1'b0;
    pf_rdata     = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_forced)                 w_next = PF;
        else if (l2_read || l2_write) w_next = L2;
        else if (pf_read)             w_next = PF;
      end
      L2: begin
        pmem_read    = l2_read;
        pmem_write   = l2_write;
        pmem_address = l2_address;
        pmem_wdata   = l2_wdata;
        l2_resp      = pmem_resp;
        l2_rdata     = pmem_rdata;
        if (pmem_resp) w_next = IDLE;
      end
      PF: begin
        pmem_read    = 1'b1;
        pmem_address = pf_address;
        pf_resp      = pmem_resp;
        pf_rdata     = pmem_rdata;
        if (w_merge) begin
          l2_resp  = pmem_resp;
          l2_rdata = pmem_rdata;
        end
        if (pmem_resp) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmem_sched.sv
// tb/tb_pmem_sched.sv - directed self-checking bench for pmem_sched
module tb_pmem_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         l2_read, l2_write;
  logic [15:0]  l2_address;
  logic [255:0] l2_wdata;
  logic         l2_resp;
  logic [255:0] l2_rdata;
  logic         pf_read;
  logic [15:0]  pf_address;
  logic         pf_resp;
  logic [255:0] pf_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  int n_pass = 0;
  int n_total = 0;

  pmem_sched dut (
    .clk(clk), .reset(reset),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .pf_read(pf_read), .pf_address(pf_address), .pf_resp(pf_resp), .pf_rdata(pf_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  localparam logic [255:0] D1 = {8{32'hA5A51240}};
  localparam logic [255:0] D2 = {8{32'h0BADF00D}};
  localparam logic [255:0] D3 = {8{32'h44440000}};
  localparam logic [255:0] D4 = {8{32'h20002000}};
  localparam logic [255:0] D5 = {8{32'h77770001}};
  localparam logic [255:0] WD = {8{32'hC0FFEE00}};

  initial begin
    reset = 1'b0; l2_read = 0; l2_write = 0; l2_address = '0; l2_wdata = '0;
    pf_read = 0; pf_address = '0; pmem_resp = 0; pmem_rdata = '0;
    tick(); tick();
    #1;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_l2_resp", l2_resp, 0);
    chk("rst_cnt", dut.r_starve_cnt, 0);
    reset = 1'b1;

    // Lone L2 read, memory answers in the 4th cycle of the grant
    l2_read = 1; l2_address = 16'h1240;
    #1 chk("t1_no_grant_c0", pmem_read, 0);
    tick(); chk("t1_read_c1", pmem_read, 1); chk("t1_addr", pmem_address, 16'h1240);
    tick(); tick(); chk("t1_read_c3", pmem_read, 1); chk("t1_noresp_c3", l2_resp, 0);
    tick(); pmem_resp = 1; pmem_rdata = D1;
    #1 chk("t1_read_c4", pmem_read, 1); chk("t1_l2_resp", l2_resp, 1);
    chk("t1_l2_rdata", l2_rdata, D1); chk("t1_pf_resp", pf_resp, 0);
    tick(); pmem_resp = 0; l2_read = 0;
    #1 chk("t1_idle", pmem_read, 0);

    // L2 write and prefetch together with counter 0: L2 first
    l2_write = 1; l2_address = 16'h1100; l2_wdata = WD; pf_read = 1; pf_address = 16'h3000;
    tick(); chk("t2_write", pmem_write, 1); chk("t2_noread", pmem_read, 0);
    chk("t2_wdata", pmem_wdata, WD); chk("t2_cnt", dut.r_starve_cnt, 1);
    pmem_resp = 1;
    #1 chk("t2_l2_resp", l2_resp, 1); chk("t2_pf_resp0", pf_resp, 0);
    tick(); pmem_resp = 0; l2_write = 0;
    #1 chk("t2_gap", pmem_read | pmem_write, 0);
    tick(); chk("t2_pf_grant", pmem_read, 1); chk("t2_pf_addr", pmem_address, 16'h3000);
    chk("t2_cnt_clr", dut.r_starve_cnt, 0);
    pmem_resp = 1; pmem_rdata = D2;
    #1 chk("t2_pf_resp", pf_resp, 1); chk("t2_pf_rdata", pf_rdata, D2); chk("t2_no_merge", l2_resp, 0);
    tick(); pmem_resp = 0; pf_read = 0;

    // Continuous L2 traffic starves the prefetch until it is forced
    l2_read = 1; l2_address = 16'h5000; pf_read = 1; pf_address = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t3_idle_gap", pmem_read, 0);
      tick(); chk("t3_l2_addr", pmem_address, 16'h5000);
      pmem_resp = 1;
      #1 chk("t3_l2_resp", l2_resp, 1);
      tick(); pmem_resp = 0;
    end
    #1 chk("t3_cnt_sat", dut.r_starve_cnt, 8);
    tick(); chk("t3_forced_addr", pmem_address, 16'h4000); chk("t3_cnt_zero", dut.r_starve_cnt, 0);
    pmem_resp = 1; pmem_rdata = D3;
    #1 chk("t3_pf_resp", pf_resp, 1); chk("t3_l2_nomerge", l2_resp, 0);
    tick(); pmem_resp = 0; l2_read = 0; pf_read = 0;
    tick();

    // Demand read merges onto the in-flight prefetch block
    pf_read = 1; pf_address = 16'h2000;
    tick(); chk("t4_pf_grant", pmem_address, 16'h2000);
    l2_read = 1; l2_address = 16'h201E;
    tick(); chk("t4_pf_owns", pmem_address, 16'h2000); chk("t4_wait", l2_resp, 0);
    pmem_resp = 1; pmem_rdata = D4;
    #1 chk("t4_pf_resp", pf_resp, 1); chk("t4_l2_resp", l2_resp, 1);
    chk("t4_l2_rdata", l2_rdata, D4); chk("t4_pf_rdata", pf_rdata, D4);
    tick(); pmem_resp = 0; l2_read = 0; pf_read = 0;
    #1 chk("t4_idle", pmem_read, 0);
    tick(); chk("t4_single_xfer", pmem_read, 0);

    // Reset during a prefetch, late response ignored, then a normal L2 read
    pf_read = 1; pf_address = 16'h6000;
    tick(); chk("t5_pf_grant", pmem_read, 1);
    reset = 1'b0;
    #1 chk("t5_async_drop", pmem_read, 0);
    pf_read = 0;
    tick(); reset = 1'b1; pmem_resp = 1; pmem_rdata = D2;
    #1 chk("t5_late_pf", pf_resp, 0); chk("t5_late_l2", l2_resp, 0);
    tick(); pmem_resp = 0;
    l2_read = 1; l2_address = 16'h7000;
    tick(); chk("t5_l2_grant", pmem_read, 1);
    pmem_resp = 1; pmem_rdata = D5;
    #1 chk("t5_l2_resp", l2_resp, 1); chk("t5_l2_rdata", l2_rdata, D5);
    tick(); pmem_resp = 0; l2_read = 0;
    #1 chk("t5_idle", pmem_read, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
